// File: rtl/mem_xfer_pkg.sv
// Shared types for the block load/store sequencer.
package mem_xfer_pkg;

   localparam int NREGS_C  = 16;
   localparam int ADDR_W_C = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef struct packed {
      logic                is_load;
      logic [ADDR_W_C-1:0] base;
      logic [NREGS_C-1:0]  reg_list;
      logic                writeback;
   } cmd_t;

endpackage

// File: rtl/mem_xfer_ctrl_lsb_prio_enc.sv
// Lowest-set-bit priority encoder over the remaining register mask.
module lsb_prio_enc #(
   parameter int N = 16,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] mask,
   output logic [W-1:0] idx,
   output logic         valid
);

   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (mask[i]) begin
            idx   = W'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_xfer_ctrl.sv
// Block register<->memory transfer sequencer, one register per cycle.
// Optional base+offset overflow abort: define MEM_XFER_BOUND_CHK_EN.
module mem_xfer_ctrl
   import mem_xfer_pkg::*;
#(
   parameter int NREGS  = NREGS_C,
   parameter int ADDR_W = ADDR_W_C,
   parameter int RIDX_W = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              is_load,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [NREGS-1:0]  reg_list,
   input  logic              writeback,
   output logic              busy,
   output logic              done,
   output logic              mem_ldr_str_en,
   output logic              mem_load_en,
   output logic              mem_store_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [ADDR_W-1:0] mem_i,
   output logic [RIDX_W-1:0] rf_addr,
   output logic              rf_write_en,
   output logic              rf_read_en,
   output logic              base_wb_en,
`ifdef MEM_XFER_BOUND_CHK_EN
   output logic [ADDR_W-1:0] base_wb_data,
   output logic              err
`else
   output logic [ADDR_W-1:0] base_wb_data
`endif
);

   localparam int CNT_W = $clog2(NREGS + 1);

   state_e           state_q, state_d;
   cmd_t             cmd_q, cmd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [RIDX_W-1:0] idx;
   logic             vld;
   logic [NREGS-1:0] idx_oh;
   logic             xfer;
   logic             wb_ok;
`ifdef MEM_XFER_BOUND_CHK_EN
   logic             err_q, err_d;
   logic [ADDR_W:0]  next_off;
`endif

   lsb_prio_enc #(.N(NREGS), .W(RIDX_W)) u_enc (
      .mask  (cmd_q.reg_list),
      .idx   (idx),
      .valid (vld)
   );

   assign idx_oh = NREGS'(1) << idx;
`ifdef MEM_XFER_BOUND_CHK_EN
   // Offset of the next transfer; bit ADDR_W set means it would leave memory.
   assign next_off = (ADDR_W+1)'(cmd_q.base) + (ADDR_W+1)'(cnt_q + 1'b1);
`endif

   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      cnt_d   = cnt_q;
`ifdef MEM_XFER_BOUND_CHK_EN
      err_d   = err_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (start) begin
               cmd_d.is_load   = is_load;
               cmd_d.base      = base_addr;
               cmd_d.reg_list  = reg_list;
               cmd_d.writeback = writeback;
               cnt_d   = '0;
`ifdef MEM_XFER_BOUND_CHK_EN
               err_d   = 1'b0;
`endif
               state_d = (reg_list != '0) ? XFER : DONE;
            end
         end
         XFER: begin
            cmd_d.reg_list = cmd_q.reg_list & ~idx_oh;
            cnt_d = cnt_q + 1'b1;
            if (cmd_d.reg_list == '0) begin
               state_d = DONE;
            end
`ifdef MEM_XFER_BOUND_CHK_EN
            else if (next_off[ADDR_W]) begin
               state_d = DONE;
               err_d   = 1'b1;
            end
`endif
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cmd_q   <= '0;
         cnt_q   <= '0;
`ifdef MEM_XFER_BOUND_CHK_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         cnt_q   <= cnt_d;
`ifdef MEM_XFER_BOUND_CHK_EN
         err_q   <= err_d;
`endif
      end
   end

   assign xfer = (state_q == XFER) && vld;
   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);

   assign mem_ldr_str_en = xfer;
   assign mem_load_en    = xfer & cmd_q.is_load;
   assign mem_store_en   = xfer & ~cmd_q.is_load;
   assign rf_write_en    = xfer & cmd_q.is_load;
   assign rf_read_en     = xfer & ~cmd_q.is_load;
   assign mem_addr       = xfer ? cmd_q.base : '0;
   assign mem_i          = xfer ? ADDR_W'(cnt_q) : '0;
   assign rf_addr        = xfer ? idx : '0;

`ifdef MEM_XFER_BOUND_CHK_EN
   assign err   = done & err_q;
   assign wb_ok = ~err_q;
`else
   assign wb_ok = 1'b1;
`endif
   assign base_wb_en   = done & cmd_q.writeback & wb_ok;
   assign base_wb_data = base_wb_en ? cmd_q.base + ADDR_W'(cnt_q) : '0;

endmodule

// File: tb/tb_mem_xfer_ctrl.sv
// Directed + randomized check of mem_xfer_ctrl against a list-walking model.
module tb_mem_xfer_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start, is_load, writeback;
   logic [7:0] base_addr;
   logic [15:0] reg_list;
   logic       busy, done, mem_ldr_str_en, mem_load_en, mem_store_en;
   logic [7:0] mem_addr, mem_i, base_wb_data;
   logic [3:0] rf_addr;
   logic       rf_write_en, rf_read_en, base_wb_en;
   logic       err_obs;
   int         vectors = 0;
   int         fails = 0;

`ifdef MEM_XFER_BOUND_CHK_EN
   logic err;
   assign err_obs = err;
`else
   assign err_obs = 1'b0;
`endif

   mem_xfer_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .is_load        (is_load),
      .base_addr      (base_addr),
      .reg_list       (reg_list),
      .writeback      (writeback),
      .busy           (busy),
      .done           (done),
      .mem_ldr_str_en (mem_ldr_str_en),
      .mem_load_en    (mem_load_en),
      .mem_store_en   (mem_store_en),
      .mem_addr       (mem_addr),
      .mem_i          (mem_i),
      .rf_addr        (rf_addr),
      .rf_write_en    (rf_write_en),
      .rf_read_en     (rf_read_en),
      .base_wb_en     (base_wb_en),
`ifdef MEM_XFER_BOUND_CHK_EN
      .base_wb_data   (base_wb_data),
      .err            (err)
`else
      .base_wb_data   (base_wb_data)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Control bits {busy,done,ldr_str,load,store,rf_we,rf_re,wb_en,err}.
   task automatic expect_cyc(string tag, logic [8:0] ctl, logic [7:0] ma,
                             logic [7:0] mi, logic [3:0] ra, logic [7:0] wbd);
      chk({tag, ".ctl"}, 32'({busy, done, mem_ldr_str_en, mem_load_en,
          mem_store_en, rf_write_en, rf_read_en, base_wb_en, err_obs}),
          32'(ctl));
      chk({tag, ".addr"}, 32'({mem_addr, mem_i, rf_addr, base_wb_data}),
          32'({ma, mi, ra, wbd}));
   endtask

   // Runs one command; ign = cycle to pulse a stray start, rcyc = reset cycle.
   task automatic run(string nm, bit ld, logic [7:0] b, logic [15:0] l,
                      bit wb, int ign = 0, int rcyc = 0);
      int   idx[$];
      int   n;
      bit   e;
      bit   wbe;
      logic [7:0] wbd;
      for (int i = 0; i < 16; i++) if (l[i]) idx.push_back(i);
      n = idx.size();
      e = 1'b0;
`ifdef MEM_XFER_BOUND_CHK_EN
      if (n > 256 - int'(b)) begin
         n = 256 - int'(b);
         e = 1'b1;
      end
`endif
      wbe = wb && !e;
      wbd = wbe ? 8'(int'(b) + n) : 8'h00;
      start = 1'b1; is_load = ld; base_addr = b;
      reg_list = l; writeback = wb;
      @(negedge clk);
      start = 1'b0;
      is_load = 1'($urandom); base_addr = 8'($urandom);
      reg_list = 16'($urandom); writeback = 1'($urandom);
      for (int c = 1; c <= n + 2; c++) begin
         if (c == rcyc) begin
            rst = 1'b1;
            #1;
            expect_cyc($sformatf("%s.rst", nm), 9'h0, 8'h0, 8'h0, 4'h0, 8'h0);
            #2 rst = 1'b0;
            @(negedge clk);
            return;
         end
         if (c <= n)
            expect_cyc($sformatf("%s.c%0d", nm, c),
                       {1'b1, 1'b0, 1'b1, ld, !ld, ld, !ld, 1'b0, 1'b0},
                       b, 8'(c - 1), 4'(idx[c-1]), 8'h0);
         else if (c == n + 1)
            expect_cyc($sformatf("%s.done", nm),
                       {2'b11, 5'b0, wbe, e}, 8'h0, 8'h0, 4'h0, wbd);
         else
            expect_cyc($sformatf("%s.idle", nm), 9'h0, 8'h0, 8'h0, 4'h0, 8'h0);
         if (c == ign) start = 1'b1;
         if (c < n + 2) begin
            @(negedge clk);
            start = 1'b0;
         end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; is_load = 1'b0; writeback = 1'b0;
      base_addr = 8'h0; reg_list = 16'h0;
      #1;
      expect_cyc("reset", 9'h0, 8'h0, 8'h0, 4'h0, 8'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      run("st5", 1'b0, 8'h10, 16'h0005, 1'b0);
      run("ldwb", 1'b1, 8'h20, 16'h8001, 1'b1);
      run("empty", 1'b0, 8'h33, 16'h0000, 1'b1);
      run("ffff", 1'b1, 8'h40, 16'hFFFF, 1'b1, 5);
      run("abort", 1'b1, 8'h40, 16'hFFFF, 1'b1, 0, 6);
      run("wrap", 1'b0, 8'hFE, 16'h000F, 1'b1);
      run("wrapld", 1'b1, 8'hF8, 16'hFFFF, 1'b1);

      for (int k = 0; k < 40; k++) begin
         logic [7:0]  b;
         logic [15:0] l;
         b = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(240, 255))
                                         : 8'($urandom);
         case ($urandom_range(0, 3))
            0:       l = 16'h0;
            1:       l = 16'h1 << $urandom_range(0, 15);
            default: l = 16'($urandom);
         endcase
         run($sformatf("rnd%0d", k), 1'($urandom), b, l, 1'($urandom),
             ($urandom_range(0, 1) == 1) ? 1 : 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule

// File: doc/mem_xfer_ctrl.md
Name: mem_xfer_ctrl

Overview:
- Sequencer for block (multi-register) load/store between the register file and the 256x32 data memory file.
- Accepts one command: direction, 8-bit base address and a 16-bit register list.
- Walks the set bits of the list, lowest index first, one transfer per cycle.
- Drives the memory's addr/offset/enable inputs and the register-file port. Optionally reports base writeback.

Parameters:
- NREGS, 16, number of architectural registers; width of the register list.
- ADDR_W, 8, memory address and offset width.
- RIDX_W, $clog2(NREGS), register index width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  command valid; sampled only in IDLE.
- is_load  in  1  1 = memory to registers, 0 = registers to memory.
- base_addr  in  ADDR_W  base memory address.
- reg_list  in  NREGS  bitmask of registers to transfer.
- writeback  in  1  request base-register update at completion.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.
- mem_ldr_str_en  out  1  memory access enable.
- mem_load_en  out  1  memory read enable.
- mem_store_en  out  1  memory write enable.
- mem_addr  out  ADDR_W  latched base address.
- mem_i  out  ADDR_W  transfer offset (0,1,2,...).
- rf_addr  out  RIDX_W  register index for the current transfer.
- rf_write_en  out  1  register-file write (load).
- rf_read_en  out  1  register-file read (store).
- base_wb_en  out  1  base writeback strobe.
- base_wb_data  out  ADDR_W  base_addr + transfer count.
- err  out  1  only when MEM_XFER_BOUND_CHK_EN is defined.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - Every output is 0, and the latched command and counter clear.
  - Reset mid-transfer aborts immediately. Transfers already done are not undone.
- FSM states: IDLE, XFER, DONE.
- IDLE:
  - If start=1, latch is_load, base_addr, reg_list and writeback, and clear the count.
  - Next state is XFER if reg_list≠0, otherwise DONE.
- XFER, every cycle:
  - idx = lowest set bit of the remaining mask.
  - Outputs: rf_addr=idx, mem_addr=latched base, mem_i=count, mem_ldr_str_en=1.
  - Load: mem_load_en=1 and rf_write_en=1 in the same cycle (memory read is combinational).
  - Store: mem_store_en=1 and rf_read_en=1.
  - Clear bit idx and increment count.
  - If that was the last set bit, go to DONE.
- DONE:
  - done=1 for one cycle.
  - If writeback is latched: base_wb_en=1 and base_wb_data = base + count, modulo 2^ADDR_W.
  - Then go to IDLE.
- Latency: start accepted at edge 0; N set bits give transfers in cycles 1..N, done in cycle N+1, busy high in cycles 1..N+1.
- Empty list: done is asserted in cycle 1 with no memory or register enables.
- start while busy is ignored; there is no queueing.
- Back-to-back: start may be asserted in the cycle after done.
- Enables are low in IDLE and DONE.
- Address arithmetic: base+offset wraps modulo 256; the memory performs the add.

Optional Feature:
- Macro: MEM_XFER_BOUND_CHK_EN.
- Defined:
  - Before each transfer, check base + count > 2^ADDR_W - 1.
  - On overflow, issue no enables that cycle and go to DONE.
  - DONE asserts done together with err=1, and base_wb_en is suppressed.
- Undefined: offsets wrap silently, and the err port does not exist.

Decomposition:
- Package mem_xfer_pkg holds:
  - the state enum (IDLE, XFER, DONE);
  - constants NREGS_C=16 and ADDR_W_C=8;
  - the command struct {is_load, base, reg_list, writeback}.
- One sub-module, lsb_prio_enc, finds the lowest set bit. It is a NREGS-bit mask in, with outputs index and valid.

Test Plan:
- Store, base 8'h10, reg_list 16'h0005:
  - cycle 1: rf_addr=0, mem_i=0, store_en=1;
  - cycle 2: rf_addr=2, mem_i=1;
  - cycle 3: done=1, busy=0 in cycle 4.
- Load with writeback, base 8'h20, reg_list 16'h8001:
  - rf_write_en with rf_addr 0, then 15;
  - DONE gives base_wb_en=1, base_wb_data=8'h22.
- reg_list 16'h0000 -> done in cycle 1; mem_ldr_str_en, rf_write_en and rf_read_en stay 0 throughout.
- Load of 16'hFFFF:
  - 16 transfers with mem_i 0..15 and rf_addr 0..15, done in cycle 17;
  - start pulsed in cycle 5 is ignored;
  - rerun with rst in cycle 6 -> all enables 0 and busy 0 immediately.
- Wrap, base 8'hFE, list 16'h000F:
  - macro undefined: 4 transfers at mem_i 0..3, done in cycle 5;
  - macro defined: 2 transfers, then done=1 and err=1 in cycle 3, base_wb_en=0.
